// File: rtl/i2s_pkg.sv
// i2s_pkg: shared widths and constants for the I2S frame transmitter
package i2s_pkg;
    localparam int SAMPLE_W    = 24;
    localparam int SLOT_W      = 32;
    localparam int CLK_DIV_DEF = 4;
    localparam int FRAME_W     = 2 * SLOT_W;
    localparam int CNT_W       = $clog2(FRAME_W);
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk into the registered I2S bit clock with edge strobes
module i2s_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic bclk_rise,
    output logic bclk_fall
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [DW-1:0] div_cnt;
    logic          wrap;
    assign wrap      = div_cnt == DW'(CLK_DIV - 1);
    assign bclk_rise = wrap && !bclk;
    assign bclk_fall = wrap && bclk;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            bclk    <= bclk ^ wrap;
        end
    end
endmodule

// File: rtl/i2s_frame_tx.sv
// i2s_frame_tx: serialises stereo sample pairs into fixed-slot I2S frames
module i2s_frame_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] left_data,
    input  logic [SAMPLE_W-1:0] right_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                frame_start,
    output logic                underrun
);
    logic                bclk_fall, accept, load, right_slot;
    logic [CNT_W-1:0]    bit_cnt, nxt_cnt, slot_j;
    logic [SAMPLE_W-1:0] hold_l, hold_r, frame_l, frame_r, load_l, load_r, word, shifted;

    i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
        .clk       (clk),
        .rst       (rst),
        .bclk      (bclk),
        .bclk_rise (),
        .bclk_fall (bclk_fall)
    );

    // the bit sent on the wrap-to-0 fall must come from the word being loaded now
    always_comb begin
        nxt_cnt    = bit_cnt == CNT_W'(FRAME_W - 1) ? '0 : bit_cnt + 1'b1;
        right_slot = nxt_cnt >= CNT_W'(SLOT_W);
        slot_j     = right_slot ? nxt_cnt - CNT_W'(SLOT_W) : nxt_cnt;
        accept     = in_valid && in_ready;
        load       = bclk_fall && nxt_cnt == '0;
        load_l     = in_ready ? '0 : hold_l;
        load_r     = in_ready ? '0 : hold_r;
        word       = nxt_cnt == '0 ? load_l : (right_slot ? frame_r : frame_l);
        shifted    = word << slot_j;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= CNT_W'(FRAME_W - 1);
            lrclk       <= 1'b0;
            sdata       <= 1'b0;
            in_ready    <= 1'b1;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            frame_l     <= '0;
            frame_r     <= '0;
        end else begin
            frame_start <= load;
            underrun    <= load && in_ready;
            in_ready    <= accept ? 1'b0 : (load ? 1'b1 : in_ready);
            if (accept) begin
                hold_l <= left_data;
                hold_r <= right_data;
            end
            if (load) begin
                frame_l <= load_l;
                frame_r <= load_r;
            end
            if (bclk_fall) begin
                bit_cnt <= nxt_cnt;
                sdata   <= shifted[SAMPLE_W-1];
                if (nxt_cnt == CNT_W'(SLOT_W - 1))
                    lrclk <= 1'b1;
                else if (nxt_cnt == CNT_W'(FRAME_W - 1))
                    lrclk <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_frame_tx.sv
// tb_i2s_frame_tx: scoreboard bench for the I2S frame transmitter at CLK_DIV=2
module tb_i2s_frame_tx;
    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        ur;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [23:0] left_data = '0, right_data = '0;
    logic        in_ready, bclk, lrclk, sdata, frame_start, underrun;

    exp_t        exp_q[$];
    exp_t        cur;
    int          errors = 0, checks = 0, cyc = 0, prev_fs = 0, first_fs = 0, last_rise = -1;
    int          k = 0, frames_done = 0, rel_cyc = 0, nacc = 0;
    bit          active = 0, have_prev = 0, bad_per = 0, bclk_q = 0;
    logic [63:0] bits, lr;

    i2s_frame_tx #(.CLK_DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .left_data   (left_data),
        .right_data  (right_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // frames are received on rising bclk; an empty queue means an idle (underrun) frame
    always @(negedge clk) begin
        if (rst) begin
            active = 0;
            have_prev = 0;
            last_rise = -1;
        end else begin
            if (frame_start) begin
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                else cur = '{l: 24'h0, r: 24'h0, ur: 1'b1};
                checks++;
                if (underrun !== cur.ur) begin errors++; $display("FAIL frame_underrun got=%b exp=%b", underrun, cur.ur); end
                checks++;
                if (active) begin errors++; $display("FAIL frame_short got=%0d bits exp=64", k); end
                if (have_prev) begin
                    checks++;
                    if (cyc - prev_fs != 256) begin errors++; $display("FAIL frame_period got=%0d exp=256", cyc - prev_fs); end
                end else first_fs = cyc;
                have_prev = 1;
                prev_fs = cyc;
                active = 1;
                k = 0;
                bad_per = 0;
            end
            if (bclk && !bclk_q) begin
                if (last_rise >= 0 && cyc - last_rise != 4) bad_per = 1;
                last_rise = cyc;
                if (active) begin
                    bits[63-k] = sdata;
                    lr[63-k] = lrclk;
                    k++;
                    if (k == 64) begin
                        checks++;
                        if (bits !== {cur.l, 8'h00, cur.r, 8'h00}) begin errors++; $display("FAIL frame_data got=%h exp=%h", bits, {cur.l, 8'h00, cur.r, 8'h00}); end
                        checks++;
                        if (lr !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL frame_lrclk got=%h exp=%h", lr, 64'h0000_0001_FFFF_FFFE); end
                        checks++;
                        if (bad_per) begin errors++; $display("FAIL bclk_period got=irregular exp=4"); end
                        active = 0;
                        frames_done++;
                    end
                end
            end
        end
        bclk_q = bclk;
    end

    task automatic wait_fs();
        bit ok = 0;
        for (int i = 0; i < 700 && !ok; i++) begin
            @(negedge clk);
            ok = frame_start;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_frame_start got=none exp=pulse"); end
    endtask

    task automatic wait_done(input int target, input int lim);
        bit ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = frames_done >= target;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_frames got=%0d exp=%0d", frames_done, target); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk got=%b exp=0", bclk); end
        if (lrclk !== 1'b0) begin errors++; $display("FAIL reset_lrclk got=%b exp=0", lrclk); end
        if (sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata got=%b exp=0", sdata); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic test_idle();
        wait_done(2, 800);
        checks++;
        if (first_fs - rel_cyc != 4) begin errors++; $display("FAIL first_frame_delay got=%0d exp=4", first_fs - rel_cyc); end
    endtask

    task automatic test_lrclk();
        int rise = -1, fall = -1;
        logic lq;
        wait_fs();
        lq = lrclk;
        for (int c = 1; c <= 256; c++) begin
            @(negedge clk);
            if (lrclk && !lq) rise = c;
            if (!lrclk && lq) fall = c;
            lq = lrclk;
        end
        checks += 2;
        if (rise != 124) begin errors++; $display("FAIL lrclk_rise got=%0d exp=124", rise); end
        if (fall != 252) begin errors++; $display("FAIL lrclk_fall got=%0d exp=252", fall); end
    endtask

    task automatic test_sample();
        int d;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL sample_ready_before got=%b exp=1", in_ready); end
        left_data = 24'hA5A5A5;
        right_data = 24'h3C3C3C;
        in_valid = 1'b1;
        exp_q.push_back('{l: 24'hA5A5A5, r: 24'h3C3C3C, ur: 1'b0});
        d = frames_done;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL sample_ready_drop got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        wait_done(d + 1, 600);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL sample_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_underrun_race();
        int d;
        wait_fs();
        repeat (255) @(negedge clk);
        left_data = 24'h800001;
        right_data = 24'h7FFFFE;
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        checks += 3;
        if (underrun !== 1'b1) begin errors++; $display("FAIL race_underrun got=%b exp=1", underrun); end
        if (frame_start !== 1'b1) begin errors++; $display("FAIL race_frame_start got=%b exp=1", frame_start); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL race_accept got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        exp_q.push_back('{l: 24'h800001, r: 24'h7FFFFE, ur: 1'b0});
        d = frames_done;
        wait_fs();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL race_ready_return got=%b exp=1", in_ready); end
        wait_done(d + 2, 800);
    endtask

    task automatic test_back_to_back();
        int d0;
        wait_fs();
        @(negedge clk);
        d0 = frames_done;
        fork
            begin
                logic [23:0] v = 24'h000100;
                bit          took;
                int          n = 0;
                left_data = v;
                right_data = ~v;
                in_valid = 1'b1;
                for (int c = 0; c < 1000; c++) begin
                    took = in_ready;
                    if (took) begin
                        exp_q.push_back('{l: v, r: ~v, ur: 1'b0});
                        n++;
                    end
                    @(negedge clk);
                    if (took) begin
                        v++;
                        left_data = v;
                        right_data = ~v;
                    end
                end
                in_valid = 1'b0;
                nacc = n;
            end
        join_none
        wait_done(d0 + 5, 3000);
        checks += 2;
        if (nacc != 4) begin errors++; $display("FAIL stream_accepts got=%0d exp=4", nacc); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL stream_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int d;
        wait_fs();
        @(negedge clk);
        left_data = 24'h123456;
        right_data = 24'hFFFFFF;
        in_valid = 1'b1;
        exp_q.push_back('{l: 24'h123456, r: 24'hFFFFFF, ur: 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        wait_fs();
        repeat (100) @(negedge clk);
        left_data = 24'h654321;
        right_data = 24'h0FF0F0;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL pending_accept got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        repeat (49) @(negedge clk);
        checks += 3;
        if (bclk !== 1'b1) begin errors++; $display("FAIL mid_bclk got=%b exp=1", bclk); end
        if (lrclk !== 1'b1) begin errors++; $display("FAIL mid_lrclk got=%b exp=1", lrclk); end
        if (sdata !== 1'b1) begin errors++; $display("FAIL mid_sdata got=%b exp=1", sdata); end
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks += 6;
        if (bclk !== 1'b0) begin errors++; $display("FAIL rst_mid_bclk got=%b exp=0", bclk); end
        if (lrclk !== 1'b0) begin errors++; $display("FAIL rst_mid_lrclk got=%b exp=0", lrclk); end
        if (sdata !== 1'b0) begin errors++; $display("FAIL rst_mid_sdata got=%b exp=0", sdata); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_start got=%b exp=0", frame_start); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL rst_mid_underrun got=%b exp=0", underrun); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        d = frames_done;
        wait_done(d + 1, 600);
        checks++;
        if (first_fs - rel_cyc != 4) begin errors++; $display("FAIL restart_delay got=%0d exp=4", first_fs - rel_cyc); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_lrclk();
        test_sample();
        test_underrun_race();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
